// File: rtl/mem_rr_arbiter_if.sv
// Requester/memory handshake bundle for mem_rr_arbiter: level requests, done pulse, registered grant.
// master = requesters + memory side, slave = arbiter.
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req;
  logic               mem_done;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               busy;
  logic               timeout_err;

  modport master (
    output req, mem_done,
    input  grant, grant_id, busy, timeout_err
  );

  modport slave (
    input  req, mem_done,
    output grant, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin memory-port arbiter, grant locked until mem_done; 1-cycle req->grant, zero-idle handoff.
// Requesters hold req (level) until granted; MEM_ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYCLES.
module mem_rr_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic             clk,
  input logic             reset,
  mem_rr_arbiter_if.slave arb
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_W-1:0]    id_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] req_v;
  logic [ID_W-1:0]    owner_nxt;
  logic [ID_W-1:0]    base;
  logic [ID_W-1:0]    win_id;
  logic               win_vld;
  logic               tmo_hit;
  logic               rel;

  generate
    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
      $error("mem_rr_arbiter: NUM_REQ and TIMEOUT_CYCLES must both be >= 2");
    end
  endgenerate

  assign req_v     = arb.req;
  assign owner_nxt = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
  assign rel       = (state == BUSY) && (arb.mem_done || tmo_hit);
  // On release the search starts just past the owner, so a still-requesting owner ends up last.
  assign base      = (state == BUSY) ? owner_nxt : ptr;

  always_comb begin
    logic [2*NUM_REQ-1:0] scan;
    int                   sum;
    win_vld = 1'b0;
    win_id  = '0;
    sum     = 0;
    scan    = {req_v, req_v} >> base;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && scan[0]) begin
        win_vld = 1'b1;
        sum     = int'(base) + i;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win_id  = ID_W'(sum);
      end
      scan = scan >> 1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= BUSY;
            grant_q <= NUM_REQ'(1) << win_id;
            id_q    <= win_id;
            busy_q  <= 1'b1;
          end
        end
        BUSY: begin
          if (rel) begin
            ptr <= owner_nxt;
            if (win_vld) begin
              grant_q <= NUM_REQ'(1) << win_id;
              id_q    <= win_id;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
              id_q    <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_err_q;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // A coincident mem_done wins: normal release, no error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= (state == BUSY) && tmo_hit && !arb.mem_done;
      if (state != BUSY || rel) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign arb.timeout_err = tmo_err_q;
`else
  assign tmo_hit         = 1'b0;
  assign arb.timeout_err = 1'b0;
`endif

  assign arb.grant    = grant_q;
  assign arb.grant_id = id_q;
  assign arb.busy     = busy_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: 4- and 3-requester instances, vector tables through a scoreboard queue,
// plus hand sequences for reset mid-transaction and hang/timeout release.
module tb_mem_rr_arbiter;
  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
  } vec_t;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  vec_t sb[$];
  vec_t tab4[26];
  vec_t tab3[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.NUM_REQ(4), .ID_W(2)) if4 ();
  mem_rr_arbiter_if #(.NUM_REQ(3), .ID_W(2)) if3 ();

  mem_rr_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(8)) u_arb4 (
    .clk   (clk),
    .reset (reset),
    .arb   (if4)
  );

  mem_rr_arbiter #(.NUM_REQ(3), .ID_W(2), .TIMEOUT_CYCLES(8)) u_arb3 (
    .clk   (clk),
    .reset (reset),
    .arb   (if3)
  );

  function automatic vec_t mk(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] id, input logic b);
    vec_t v;
    v.req = r; v.done = d; v.grant = g; v.id = id; v.busy = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic apply(input string tag, input int k, input vec_t v, input bit on3);
    vec_t       e;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       err;
    if (on3) begin
      if3.req = v.req[2:0]; if3.mem_done = v.done;
    end else begin
      if4.req = v.req;      if4.mem_done = v.done;
    end
    sb.push_back(v);
    tick();
    e = sb.pop_front();
    if (on3) begin
      g = {1'b0, if3.grant}; id = if3.grant_id; b = if3.busy; err = if3.timeout_err;
    end else begin
      g = if4.grant;         id = if4.grant_id; b = if4.busy; err = if4.timeout_err;
    end
    check($sformatf("%s[%0d].grant", tag, k), g, e.grant);
    check($sformatf("%s[%0d].busy", tag, k), 4'(b), 4'(e.busy));
    if (e.busy) check($sformatf("%s[%0d].grant_id", tag, k), 4'(id), 4'(e.id));
    check($sformatf("%s[%0d].timeout_err", tag, k), 4'(err), 4'd0);
  endtask

  initial begin
    reset = 1'b1;
    if4.req = '0; if4.mem_done = 1'b0;
    if3.req = '0; if3.mem_done = 1'b0;

    // lock/hold, pointer after release, 4-way rotation, done ignored while idle
    tab4[0]  = mk(4'b0100, 0, 4'b0100, 2, 1);
    tab4[1]  = mk(4'b0100, 0, 4'b0100, 2, 1);
    tab4[2]  = mk(4'b0000, 0, 4'b0100, 2, 1);
    tab4[3]  = mk(4'b0000, 0, 4'b0100, 2, 1);
    tab4[4]  = mk(4'b0000, 0, 4'b0100, 2, 1);
    tab4[5]  = mk(4'b0000, 1, 4'b0000, 0, 0);
    tab4[6]  = mk(4'b1111, 0, 4'b1000, 3, 1);
    tab4[7]  = mk(4'b1111, 0, 4'b1000, 3, 1);
    tab4[8]  = mk(4'b1111, 1, 4'b0001, 0, 1);
    tab4[9]  = mk(4'b1111, 0, 4'b0001, 0, 1);
    tab4[10] = mk(4'b1111, 0, 4'b0001, 0, 1);
    tab4[11] = mk(4'b1111, 1, 4'b0010, 1, 1);
    tab4[12] = mk(4'b1111, 0, 4'b0010, 1, 1);
    tab4[13] = mk(4'b1111, 0, 4'b0010, 1, 1);
    tab4[14] = mk(4'b1111, 1, 4'b0100, 2, 1);
    tab4[15] = mk(4'b1111, 0, 4'b0100, 2, 1);
    tab4[16] = mk(4'b1111, 0, 4'b0100, 2, 1);
    tab4[17] = mk(4'b1111, 1, 4'b1000, 3, 1);
    tab4[18] = mk(4'b1111, 0, 4'b1000, 3, 1);
    tab4[19] = mk(4'b1111, 0, 4'b1000, 3, 1);
    tab4[20] = mk(4'b1111, 1, 4'b0001, 0, 1);
    tab4[21] = mk(4'b0000, 1, 4'b0000, 0, 0);
    tab4[22] = mk(4'b0000, 1, 4'b0000, 0, 0);
    tab4[23] = mk(4'b1111, 0, 4'b0010, 1, 1);
    tab4[24] = mk(4'b1111, 1, 4'b0100, 2, 1);
    tab4[25] = mk(4'b0000, 1, 4'b0000, 0, 0);

    // non-power-of-2 wrap, owner re-grant back-to-back, owner at lowest priority
    tab3[0] = mk(4'b0100, 0, 4'b0100, 2, 1);
    tab3[1] = mk(4'b0101, 0, 4'b0100, 2, 1);
    tab3[2] = mk(4'b0101, 1, 4'b0001, 0, 1);
    tab3[3] = mk(4'b0101, 0, 4'b0001, 0, 1);
    tab3[4] = mk(4'b0100, 1, 4'b0100, 2, 1);
    tab3[5] = mk(4'b0100, 1, 4'b0100, 2, 1);
    tab3[6] = mk(4'b0110, 1, 4'b0010, 1, 1);
    tab3[7] = mk(4'b0110, 1, 4'b0100, 2, 1);
    tab3[8] = mk(4'b0000, 1, 4'b0000, 0, 0);

    tick(); tick();
    check("rst.grant4", if4.grant, 4'd0);
    check("rst.busy4", 4'(if4.busy), 4'd0);
    check("rst.id4", 4'(if4.grant_id), 4'd0);
    check("rst.err4", 4'(if4.timeout_err), 4'd0);
    check("rst.grant3", 4'(if3.grant), 4'd0);
    check("rst.busy3", 4'(if3.busy), 4'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle[%0d].grant", i), if4.grant, 4'd0);
      check($sformatf("idle[%0d].busy", i), 4'(if4.busy), 4'd0);
      check($sformatf("idle[%0d].grant_id", i), 4'(if4.grant_id), 4'd0);
      check($sformatf("idle[%0d].grant3", i), 4'(if3.grant), 4'd0);
    end

    for (int k = 0; k < 26; k++) apply("tab4", k, tab4[k], 1'b0);
    if4.req = '0; if4.mem_done = 1'b0;
    for (int k = 0; k < 9; k++) apply("tab3", k, tab3[k], 1'b1);
    if3.req = '0; if3.mem_done = 1'b0;

    // reset while busy with ptr=2: afterwards 3'b110 must pick 1, not 2
    if3.req = 3'b010;
    tick();
    check("rstmid.pre_grant1", 4'(if3.grant), 4'b0010);
    if3.req = 3'b001; if3.mem_done = 1'b1;
    tick();
    if3.mem_done = 1'b0;
    check("rstmid.pre_grant0", 4'(if3.grant), 4'b0001);
    tick(); tick();
    check("rstmid.busy_before", 4'(if3.busy), 4'd1);
    #2 reset = 1'b1;
    #1;
    check("rstmid.grant", 4'(if3.grant), 4'd0);
    check("rstmid.busy", 4'(if3.busy), 4'd0);
    check("rstmid.grant_id", 4'(if3.grant_id), 4'd0);
    check("rstmid.err", 4'(if3.timeout_err), 4'd0);
    tick();
    reset = 1'b0;
    if3.req = 3'b110;
    tick();
    check("rstmid.post_grant", 4'(if3.grant), 4'b0010);
    check("rstmid.post_id", 4'(if3.grant_id), 4'd1);
    if3.req = '0; if3.mem_done = 1'b1;
    tick();
    if3.mem_done = 1'b0;
    check("rstmid.release", 4'(if3.busy), 4'd0);

    // hung owner 0 with 1 pending: timeout build releases 8 cycles after grant
    if4.req = 4'b0011;
    tick();
    check("hang.grant", if4.grant, 4'b0001);
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("hang.hold[%0d]", i), if4.grant, 4'b0001);
      check($sformatf("hang.err[%0d]", i), 4'(if4.timeout_err), 4'd0);
    end
    tick();
    check("hang.at8.grant", if4.grant, TMO ? 4'b0010 : 4'b0001);
    check("hang.at8.err", 4'(if4.timeout_err), TMO ? 4'd1 : 4'd0);
    tick();
    check("hang.at9.grant", if4.grant, TMO ? 4'b0010 : 4'b0001);
    check("hang.at9.err", 4'(if4.timeout_err), 4'd0);
    for (int i = 10; i < 16; i++) begin
      tick();
      check($sformatf("hang.hold2[%0d]", i), if4.grant, TMO ? 4'b0010 : 4'b0001);
    end
    if4.mem_done = 1'b1;
    tick();
    if4.mem_done = 1'b0;
    check("hang.done.grant", if4.grant, TMO ? 4'b0001 : 4'b0010);
    check("hang.done.err", 4'(if4.timeout_err), 4'd0);
    tick();
    check("hang.done.err_after", 4'(if4.timeout_err), 4'd0);
    if4.req = '0; if4.mem_done = 1'b1;
    tick();
    if4.mem_done = 1'b0;
    check("hang.final_busy", 4'(if4.busy), 4'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Parametrised round-robin arbiter granting one of `NUM_REQ` cache/DMA requesters exclusive access to the shared memory port. It is the next generation of the two-way I/D-cache arbiter. It adds N requesters, transaction locking (the grant is held until memory signals completion), back-to-back handoff and an optional hang-timeout. It sits between the L1 cache miss engines and the single memory interface.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, must be ≥2.
- `ID_W`, default `$clog2(NUM_REQ)` (minimum 1): width of `grant_id`.
- `TIMEOUT_CYCLES`, default 256: BUSY cycles before forced release. Used only with the timeout macro. Must be ≥2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `req`  in  `NUM_REQ`  per-requester request level. Bit 0 is the I-cache, bit 1 is the D-cache.
- `mem_done`  in  1  single-cycle pulse from memory: the current transaction has completed.
- `grant`  out  `NUM_REQ`  one-hot grant, registered. All zero when idle.
- `grant_id`  out  `ID_W`  binary index of the granted requester. Valid only while `busy`=1.
- `busy`  out  1  a transaction is owned.
- `timeout_err`  out  1  one-cycle pulse on forced release.

## Operation
- State machine has two states:
  - IDLE (`busy`=0)
  - BUSY (`busy`=1, exactly one `grant` bit set)
- Round-robin pointer `ptr` (`ID_W` bits) holds the highest-priority index. Search order is `ptr`, `ptr+1`, …, wrapping modulo `NUM_REQ`.
- IDLE:
  - If any `req` bit is set, pick the winner `w` by search from `ptr`. Set `grant`=onehot(`w`) and `grant_id`=`w`, then go to BUSY.
  - `mem_done` is ignored in IDLE.
- BUSY:
  - The grant is locked. Changes on `req`, including the owner dropping its `req`, do not alter `grant`.
  - On `mem_done`=1, set `ptr` ← owner+1 (mod `NUM_REQ`, with wrap for non-power-of-2 counts). Then re-arbitrate in the same edge over the current `req`, searching from the new `ptr`. The owner's bit counts as a request if still set, at lowest priority.
  - If a winner exists, go to BUSY with the new grant (back-to-back, no idle cycle). Otherwise clear `grant` and go to IDLE.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,…,`NUM_REQ`-1,0,… with one grant per transaction.
- `ptr` changes only on release (`mem_done` or timeout). Granting out of IDLE does not change it.
- Reset, at any time including mid-transaction, forces:
  - `grant`=0, `grant_id`=0, `busy`=0, `timeout_err`=0
  - `ptr`=0, timeout counter=0, state IDLE
- Any in-flight transaction is abandoned. The memory side is reset by the same `reset`.

## Timing
- Arbitration latency is 1 cycle: `req` sampled at edge N produces `grant` visible after edge N.
- Handoff latency: `mem_done` at edge N puts the next owner's grant after edge N, so the port has zero idle cycles.
- All outputs are registered. There are no combinational paths from `req`/`mem_done` to outputs.
- A requester must keep `req` asserted until it observes its `grant` bit. `req` sampled while another requester owns the port is not lost, because it is level-based.
- `mem_done` and the timeout expiring in the same cycle are treated as a normal `mem_done`: no `timeout_err`.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on each entry to BUSY (including handoff) and increments every BUSY cycle without `mem_done`.
  - When it reaches `TIMEOUT_CYCLES`-1, the grant is released exactly as on `mem_done` (pointer advance plus re-arbitration), and `timeout_err` pulses for 1 cycle.
- Undefined:
  - No counter is instantiated, and `timeout_err` is tied to 0.
  - A hung transaction holds the grant indefinitely.

## Test plan
- Reset, then `req`=0 for 5 cycles → `grant`=0, `busy`=0, `grant_id`=0 every cycle.
- `NUM_REQ`=4, `req`=4'b0100 at edge 1 → `grant`=4'b0100 and `grant_id`=2 after edge 1. Owner drops `req` at edge 3 → `grant` still held. `mem_done` at edge 6 → `grant`=0, `busy`=0, `ptr`=3.
- `NUM_REQ`=4, `req`=4'b1111 held, `mem_done` pulsed every 3rd cycle → grant sequence 0,1,2,3,0 with no idle cycle between owners.
- `NUM_REQ`=3, owner 2 completes with `req`=3'b101 → next grant is 0 (pointer wraps from 3 to 0). Repeat with only `req[2]` set → 2 is re-granted back-to-back.
- Assert `reset` in BUSY, 2 cycles after the grant → all outputs are 0 immediately. After release, `req`=3'b110 → grant 1 (pointer reset to 0).
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, grant 0 with no `mem_done` → release 8 cycles after the grant, `timeout_err`=1 for one cycle, next pending requester granted. With `mem_done` at cycle 8 → no `timeout_err`.
